// File: rtl/superh16_sched_dispatch.sv
// In-order dispatch queue: compacts renamed micro-ops into a circular buffer and
// steers the oldest entries, GROUP at a time, to up to BANKS_PER_CYCLE ready banks.
package superh16_sched_pkg;
    typedef struct packed {
        logic [7:0] rob_id;
        logic [7:0] opcode;
        logic [7:0] pdst;
        logic [7:0] psrc;
    } renamed_inst_t;
endpackage

module superh16_sched_dispatch
    import superh16_sched_pkg::*;
#(
    parameter int NUM_BANKS       = 4,
    parameter int DEPTH           = 32,
    parameter int IN_WIDTH        = 8,
    parameter int GROUP           = 4,
    parameter int BANKS_PER_CYCLE = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [IN_WIDTH-1:0]                   in_valid,
    input  renamed_inst_t [IN_WIDTH-1:0]          in_inst,
    output logic                                  in_ready,
    input  logic [NUM_BANKS-1:0]                  bank_alloc_ready,
    output logic [NUM_BANKS-1:0][GROUP-1:0]       bank_alloc_valid,
    output renamed_inst_t [NUM_BANKS-1:0][GROUP-1:0] bank_alloc_inst,
    input  logic                                  flush,
    output logic [$clog2(DEPTH):0]                occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(NUM_BANKS);
    localparam int CW = AW + 1;

    renamed_inst_t          mem_q [DEPTH];
    logic [DEPTH-1:0]       vld_q;
    logic [AW-1:0]          head_q, tail_q;
    logic [CW-1:0]          count_q;
    logic [BW-1:0]          rr_q, rr_d;

    logic                   go, enq_ok, full_run;
    logic [CW-1:0]          enq_n, deq_n, avail;
    logic [IN_WIDTH-1:0]    wr_en;
    logic [IN_WIDTH-1:0][AW-1:0] wr_idx;
    logic [BANKS_PER_CYCLE-1:0]  has;
    logic [BANKS_PER_CYCLE-1:0][BW-1:0] sel;
    logic [BANKS_PER_CYCLE-1:0][CW-1:0] grant;
    logic [BW-1:0]          bidx;
    logic [AW-1:0]          ridx;
    int                     nsel;

    assign in_ready  = (CW'(DEPTH) - count_q) >= CW'(IN_WIDTH);
    assign occupancy = count_q;
    assign go        = rst_n && !flush;
    assign enq_ok    = in_ready && !flush;

    // Compacting enqueue: each valid lane takes the next free slot after tail.
    always_comb begin
        enq_n  = '0;
        wr_en  = '0;
        wr_idx = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (enq_ok && in_valid[i]) begin
                wr_en[i]  = 1'b1;
                wr_idx[i] = tail_q + enq_n[AW-1:0];
                enq_n     = enq_n + CW'(1);
            end
        end
    end

    // Pick the first BANKS_PER_CYCLE ready banks, scanning upward from rr_q.
    always_comb begin
        has  = '0;
        sel  = '0;
        nsel = 0;
        bidx = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            bidx = rr_q + BW'(k);
            if (bank_alloc_ready[bidx] && nsel < BANKS_PER_CYCLE) begin
                for (int j = 0; j < BANKS_PER_CYCLE; j++)
                    if (j == nsel) begin
                        has[j] = 1'b1;
                        sel[j] = bidx;
                    end
                nsel = nsel + 1;
            end
        end
    end

    // A later bank only gets entries if every earlier bank took a full group,
    // which keeps the dispatch stream in strict program order.
    always_comb begin
        grant            = '0;
        deq_n            = '0;
        avail            = count_q;
        full_run         = go;
        rr_d             = rr_q;
        ridx             = '0;
        bank_alloc_valid = '0;
        bank_alloc_inst  = '0;
        for (int j = 0; j < BANKS_PER_CYCLE; j++) begin
            if (full_run && has[j]) begin
                grant[j] = (avail >= CW'(GROUP)) ? CW'(GROUP) : avail;
                avail    = avail - grant[j];
                deq_n    = deq_n + grant[j];
                if (grant[j] != '0)
                    rr_d = sel[j] + BW'(1);
                full_run = (grant[j] == CW'(GROUP));
            end else begin
                full_run = 1'b0;
            end
        end
        for (int j = 0; j < BANKS_PER_CYCLE; j++) begin
            for (int s = 0; s < GROUP; s++) begin
                if (CW'(s) < grant[j]) begin
                    ridx = head_q + AW'(j * GROUP + s);
                    bank_alloc_valid[sel[j]][s] = vld_q[ridx];
                    bank_alloc_inst[sel[j]][s]  = mem_q[ridx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rr_q    <= '0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_q + deq_n[AW-1:0];
            tail_q  <= tail_q + enq_n[AW-1:0];
            count_q <= count_q + enq_n - deq_n;
            rr_q    <= rr_d;
            for (int s = 0; s < BANKS_PER_CYCLE * GROUP; s++)
                if (CW'(s) < deq_n)
                    vld_q[head_q + AW'(s)] <= 1'b0;
            for (int i = 0; i < IN_WIDTH; i++)
                if (wr_en[i])
                    vld_q[wr_idx[i]] <= 1'b1;
        end
    end

    // Payload storage needs no reset; vld_q qualifies every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_WIDTH; i++)
            if (wr_en[i])
                mem_q[wr_idx[i]] <= in_inst[i];
    end

endmodule

// File: tb/tb_superh16_sched_dispatch.sv
// Bench for superh16_sched_dispatch: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_superh16_sched_dispatch;
    import superh16_sched_pkg::*;

    localparam int NB = 4, DEPTH = 32, IW = 8, G = 4, BPC = 2;

    logic                          clk = 1'b0;
    logic                          rst_n, flush;
    logic [IW-1:0]                 in_valid;
    renamed_inst_t [IW-1:0]        in_inst;
    logic                          in_ready;
    logic [NB-1:0]                 bank_alloc_ready;
    logic [NB-1:0][G-1:0]          bank_alloc_valid;
    renamed_inst_t [NB-1:0][G-1:0] bank_alloc_inst;
    logic [5:0]                    occupancy;

    always #5 clk = ~clk;

    superh16_sched_dispatch dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_inst(in_inst),
        .in_ready(in_ready), .bank_alloc_ready(bank_alloc_ready),
        .bank_alloc_valid(bank_alloc_valid), .bank_alloc_inst(bank_alloc_inst),
        .flush(flush), .occupancy(occupancy)
    );

    int            n_chk = 0, n_pass = 0;
    renamed_inst_t mq[$];
    int            mrr = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic rnd_inst();
        for (int i = 0; i < IW; i++) in_inst[i] = renamed_inst_t'($urandom);
    endtask

    // One clock: compare outputs with the model at negedge, advance the model at posedge.
    task automatic tick(input bit has_ev = 1'b0, input logic [NB*G-1:0] ev = '0);
        logic [NB-1:0][G-1:0]          ev_v;
        renamed_inst_t [NB-1:0][G-1:0] ev_i;
        int chosen[$];
        int give, pos, last, b;
        bit room, exp_rdy, active;
        @(negedge clk);
        ev_v    = '0;
        ev_i    = '0;
        pos     = 0;
        last    = -1;
        exp_rdy = (DEPTH - mq.size()) >= IW;
        active  = rst_n && !flush;
        if (active) begin
            for (int k = 0; k < NB; k++) begin
                b = (mrr + k) % NB;
                if (bank_alloc_ready[b] && chosen.size() < BPC) chosen.push_back(b);
            end
            room = 1'b1;
            for (int j = 0; j < chosen.size(); j++) begin
                if (room) begin
                    give = mq.size() - pos;
                    if (give > G) give = G;
                    for (int s = 0; s < give; s++) begin
                        ev_v[chosen[j]][s] = 1'b1;
                        ev_i[chosen[j]][s] = mq[pos + s];
                    end
                    pos += give;
                    if (give > 0) last = chosen[j];
                    room = (give == G);
                end
            end
        end
        chk("occupancy", occupancy, mq.size());
        chk("in_ready", in_ready, exp_rdy);
        chk("alloc_valid", bank_alloc_valid, ev_v);
        chk("alloc_inst", bank_alloc_inst, ev_i);
        if (has_ev) chk("directed_valid", bank_alloc_valid, ev);
        @(posedge clk);
        if (!active) begin
            mq.delete();
            mrr = 0;
        end else begin
            for (int p = 0; p < pos; p++) void'(mq.pop_front());
            if (last >= 0) mrr = (last + 1) % NB;
            if (exp_rdy)
                for (int i = 0; i < IW; i++)
                    if (in_valid[i]) mq.push_back(in_inst[i]);
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = '1; bank_alloc_ready = '1;
        rnd_inst();
        #1;
        tick(); tick();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_occ", occupancy, 0);
        chk("rst_strobes", bank_alloc_valid, 0);
        rst_n = 1'b1; in_valid = '0;
        tick();

        // single op -> bank0 slot0
        in_valid = 8'h01; rnd_inst(); tick();
        in_valid = '0; tick(1'b1, 16'h0001);
        tick();

        // full bundle with rr=1 -> bank1 and bank2 full
        in_valid = 8'hFF; rnd_inst(); tick();
        in_valid = '0; tick(1'b1, 16'h0FF0);

        // bank skip and lane compaction from rr=0
        flush = 1'b1; tick(1'b1, 16'h0000);
        flush = 1'b0;
        in_valid = 8'b0010_0101; rnd_inst(); tick();
        in_valid = '0; bank_alloc_ready = 4'b1010; tick(1'b1, 16'h0070);

        // backpressure to full, then drain across the index wrap
        bank_alloc_ready = '0;
        for (int n = 0; n < 5; n++) begin
            in_valid = 8'hFF; rnd_inst(); tick();
        end
        in_valid = '0;
        chk("bp_full_occ", occupancy, 32);
        chk("bp_full_ready", in_ready, 1'b0);
        bank_alloc_ready = 4'b0100;
        for (int c = 0; c < 12 && mq.size() != 0; c++) tick();
        chk("drain_empty", occupancy, 0);

        // flush with 20 held entries and a live bundle
        bank_alloc_ready = '0;
        in_valid = 8'hFF; rnd_inst(); tick();
        in_valid = 8'hFF; rnd_inst(); tick();
        in_valid = 8'h0F; rnd_inst(); tick();
        chk("fl_occ20", occupancy, 20);
        flush = 1'b1; in_valid = 8'hFF; bank_alloc_ready = '1; rnd_inst();
        tick(1'b1, 16'h0000);
        flush = 1'b0; in_valid = '0;
        chk("fl_occ0", occupancy, 0);
        in_valid = 8'h01; rnd_inst(); tick();
        in_valid = '0; tick(1'b1, 16'h0001);

        // random traffic with occasional flush and reset
        for (int c = 0; c < 1500; c++) begin
            in_valid = IW'($urandom);
            bank_alloc_ready = ($urandom_range(0, 3) == 0) ? '0 : NB'($urandom);
            flush = ($urandom_range(0, 49) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            rnd_inst();
            tick();
        end
        rst_n = 1'b1; flush = 1'b0; in_valid = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/superh16_sched_dispatch.md
Name: superh16_sched_dispatch

Overview:
- In-order dispatch queue between rename and the scheduler banks.
- Accepts up to 8 renamed micro-ops per cycle from rename into a 32-entry circular buffer.
- Each cycle, steers the oldest entries to at most 2 ready banks, in groups of up to 4 (one bank's per-cycle allocation width).
- Round-robin bank rotation balances occupancy across the NUM_BANKS scheduler banks.

Parameters:
NUM_BANKS, 4, number of scheduler banks fed (power of two, 2..8)
DEPTH, 32, dispatch queue entries (power of two)
IN_WIDTH, 8, rename lanes per cycle
GROUP, 4, allocation slots per bank per cycle
BANKS_PER_CYCLE, 2, maximum banks written per cycle (BANKS_PER_CYCLE*GROUP == IN_WIDTH)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  [IN_WIDTH]  rename lane valid
in_inst  in  renamed_inst_t [IN_WIDTH]  renamed micro-op per lane
in_ready  out  1  queue can accept a full IN_WIDTH bundle this cycle
bank_alloc_ready  in  [NUM_BANKS]  bank has >=GROUP free entries
bank_alloc_valid  out  [NUM_BANKS][GROUP]  per-bank per-slot allocate strobe
bank_alloc_inst  out  renamed_inst_t [NUM_BANKS][GROUP]  per-bank per-slot micro-op
flush  in  1  pipeline flush
occupancy  out  $clog2(DEPTH)+1  valid entries held

Behaviour:
- Reset is synchronous: while rst_n==0 at a clk edge, head=tail=0, count=0, rr_bank=0, all storage valid bits cleared.
- Reset is observed on any cycle, including mid-dispatch; in-flight bundles are dropped.
- Output values at and after reset: in_ready=1, occupancy=0, all bank_alloc_valid=0, bank_alloc_inst=0.
- in_ready = (DEPTH - count) >= IN_WIDTH, using registered count only (no credit from same-cycle dequeue).
- Enqueue happens when in_ready=1 and flush=0.
  - Lanes with in_valid=1 are written in ascending lane order, compacted: a gap lane consumes no slot.
  - tail advances by popcount(in_valid), modulo DEPTH.
  - in_valid while in_ready=0 is ignored; rename holds its bundle.
- Dequeue/steer is combinational from registered queue state and bank_alloc_ready; state updates on the same edge.
- Scan banks starting at rr_bank, ascending modulo NUM_BANKS; select the first up to BANKS_PER_CYCLE banks with bank_alloc_ready=1.
  - First selected bank receives entries head..head+GROUP-1, limited to count; slots are filled from slot 0 upward.
  - Second selected bank receives the next up-to-GROUP entries, only if the first group was full (GROUP entries).
  - No entry is ever skipped: strict program order.
- Unselected banks and unused slots: bank_alloc_valid=0, bank_alloc_inst=0.
- head advances by the number dispatched; count updates to count + enq - deq in the same cycle.
- rr_bank becomes (last selected bank + 1) mod NUM_BANKS. If nothing is dispatched, rr_bank is unchanged.
- No bypass: an entry enqueued at edge N is first eligible for dispatch in cycle N+1. Minimum latency is 1 cycle.
- Empty (count=0): no strobes; rr_bank holds.
- Full (count=DEPTH): in_ready=0; dispatch still proceeds.
- No ready bank: no strobes; queue holds.
- Pointer wrap: head/tail index modulo DEPTH; a group spanning index DEPTH-1 to 0 dispatches in order.
- Flush: at the edge where flush=1, clear all entries, head=tail=0, count=0, rr_bank=0.
  - During the flush cycle: all bank_alloc_valid=0 and the enqueue is discarded.
  - Every entry in this queue is younger than any flush point by construction, so no per-entry age compare is needed.
- Simultaneous enqueue + dequeue with count at boundary: allowed; count never exceeds DEPTH because of the in_ready rule.
- occupancy = registered count.

Test Plan:
- Reset: hold rst_n=0 two cycles with in_valid all 1 -> in_ready=1, occupancy=0, no bank strobes; after release occupancy stays 0.
- Single op: lane0 valid, all banks ready -> cycle+1 bank0 slot0 valid with that inst; rr_bank=1; occupancy returns to 0.
- Full bundle: 8 valid lanes, all banks ready, rr_bank=1 -> next cycle bank1 slots0-3 = ops0-3, bank2 slots0-3 = ops4-7; rr_bank=3.
- Bank skip + compaction: lanes {0,2,5} valid, bank_alloc_ready=4'b1010, rr_bank=0 -> bank1 slots0-2 = lanes 0,2,5; bank3 idle; rr_bank=2.
- Backpressure/wrap: all bank_alloc_ready=0, push four 8-wide bundles -> occupancy=32, in_ready=0, fifth bundle ignored.
  - Then one bank ready -> 4 oldest dispatched per cycle, in order across the index 31->0 wrap, until empty.
- Flush: occupancy=20 and flush=1 with in_valid active -> next cycle occupancy=0, rr_bank=0, no strobes in the flush cycle, new bundle dropped.
